// File: rtl/reg_cal_pkg.sv
// Purpose: shared types and field offsets for the multi-channel calibration control register.
// Latency: none (declarations only).
// Backpressure: none; the register bus has no stall.
package reg_cal_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ch_state_e;

  localparam int START_LSB  = 0;
  localparam int DONE_LSB   = 8;
  localparam int ERR_LSB    = 16;
  localparam int IRQ_EN_BIT = 31;
  localparam int MAX_CH     = 8;

endpackage

// File: rtl/cal_ch_fsm.sv
// Purpose: one calibration channel -- IDLE/BUSY FSM, saturating timeout counter, sticky DONE/ERR.
// Latency: start pulse and busy one edge after the launching write; done/timeout retire busy at the sampling edge.
// Backpressure: none; a launch while busy is dropped, a done while idle is dropped.
// Ports: start_req/done_clr/err_clr = decoded per-channel write bits, done_in = engine completion,
//        start = one-cycle launch pulse, busy = BUSY state, done/err = sticky status bits.
module cal_ch_fsm
  import reg_cal_pkg::*;
#(
  parameter int                   TMO_WIDTH = 16,
  parameter logic [TMO_WIDTH-1:0] TMO_LIMIT = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_req,
  input  logic done_clr,
  input  logic err_clr,
  input  logic done_in,
  output logic start,
  output logic busy,
  output logic done,
  output logic err
);

  ch_state_e            state;
  logic [TMO_WIDTH-1:0] cnt;
  logic                 timeout;

  // A zero limit disables the timeout entirely.
  assign timeout = (TMO_LIMIT != '0) && (cnt == TMO_LIMIT);
  assign busy    = (state == ST_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      start <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      start <= 1'b0;
      // W1C first; the set assignments below come later so a set on the same edge wins.
      done  <= done & ~done_clr;
      err   <= err & ~err_clr;
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state <= ST_BUSY;
            cnt   <= '0;
            start <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Completion takes priority over a timeout on the same edge.
          if (done_in) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else if (timeout) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + TMO_WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reg_register_cal_ctrl.sv
// Purpose: 32-bit calibration start/status register driving up to 8 channel engines, with level irq.
// Latency: strobes, start pulses, busy and status one edge after the access; irq one edge after status.
// Backpressure: none; every access completes in the cycle it is presented.
// Ports: reg_wr_sel/reg_wr_rd/reg_wr_data = register bus, reg_rd_out = combinational read data,
//        ch_start/ch_done/ch_busy = per-channel engine handshake, irq = interrupt level,
//        f_ctrl_wr/f_ctrl_rd = registered access strobes.
module reg_register_cal_ctrl
  import reg_cal_pkg::*;
#(
  parameter int                   REG_WIDTH = 32,
  parameter int                   CH_NUM    = 4,
  parameter int                   TMO_WIDTH = 16,
  parameter logic [TMO_WIDTH-1:0] TMO_LIMIT = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reg_wr_sel,
  input  logic                 reg_wr_rd,
  input  logic [REG_WIDTH-1:0] reg_wr_data,
  output logic [REG_WIDTH-1:0] reg_rd_out,
  output logic [CH_NUM-1:0]    ch_start,
  input  logic [CH_NUM-1:0]    ch_done,
  output logic [CH_NUM-1:0]    ch_busy,
  output logic                 irq,
  output logic                 f_ctrl_wr,
  output logic                 f_ctrl_rd
);

  if (REG_WIDTH != 32) begin : g_bad_reg_width
    $error("reg_register_cal_ctrl: REG_WIDTH must be 32");
  end
  if (CH_NUM < 1 || CH_NUM > MAX_CH) begin : g_bad_ch_num
    $error("reg_register_cal_ctrl: CH_NUM must be 1..8");
  end

  logic              wr;
  logic              rd;
  logic              irq_en;
  logic [CH_NUM-1:0] ch_done_st;
  logic [CH_NUM-1:0] ch_err_st;
  logic              unused_wr_bits;

  assign wr = reg_wr_sel & reg_wr_rd;
  assign rd = reg_wr_sel & ~reg_wr_rd;

  // Reserved and out-of-range field bits are intentionally ignored on write.
  assign unused_wr_bits = ^reg_wr_data;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    cal_ch_fsm #(
      .TMO_WIDTH (TMO_WIDTH),
      .TMO_LIMIT (TMO_LIMIT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_req (wr & reg_wr_data[START_LSB + i]),
      .done_clr  (wr & reg_wr_data[DONE_LSB + i]),
      .err_clr   (wr & reg_wr_data[ERR_LSB + i]),
      .done_in   (ch_done[i]),
      .start     (ch_start[i]),
      .busy      (ch_busy[i]),
      .done      (ch_done_st[i]),
      .err       (ch_err_st[i])
    );
  end

  // Read data is pure state: no side effects, unimplemented channel bits read 0.
  always_comb begin
    reg_rd_out = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      reg_rd_out[START_LSB + i] = ch_busy[i];
      reg_rd_out[DONE_LSB + i]  = ch_done_st[i];
      reg_rd_out[ERR_LSB + i]   = ch_err_st[i];
    end
    reg_rd_out[IRQ_EN_BIT] = irq_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      f_ctrl_wr <= 1'b0;
      f_ctrl_rd <= 1'b0;
    end else begin
      if (wr) begin
        irq_en <= reg_wr_data[IRQ_EN_BIT];
      end
      // Built from pre-edge status, so irq trails a status change by one edge.
      irq       <= irq_en & (|(ch_done_st | ch_err_st));
      f_ctrl_wr <= wr;
      f_ctrl_rd <= rd;
    end
  end

endmodule

// File: tb/tb_reg_register_cal_ctrl.sv
// Purpose: self-checking bench for reg_register_cal_ctrl (CH_NUM=4, TMO_LIMIT=10).
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_register_cal_ctrl;

  localparam int TMO = 10;

  logic        clk;
  logic        rst_n;
  logic        reg_wr_sel;
  logic        reg_wr_rd;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_out;
  logic [3:0]  ch_start;
  logic [3:0]  ch_done;
  logic [3:0]  ch_busy;
  logic        irq;
  logic        f_ctrl_wr;
  logic        f_ctrl_rd;

  int checks   = 0;
  int failures = 0;

  reg_register_cal_ctrl #(
    .REG_WIDTH (32),
    .CH_NUM    (4),
    .TMO_WIDTH (16),
    .TMO_LIMIT (16'd10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_wr_sel  (reg_wr_sel),
    .reg_wr_rd   (reg_wr_rd),
    .reg_wr_data (reg_wr_data),
    .reg_rd_out  (reg_rd_out),
    .ch_start    (ch_start),
    .ch_done     (ch_done),
    .ch_busy     (ch_busy),
    .irq         (irq),
    .f_ctrl_wr   (f_ctrl_wr),
    .f_ctrl_rd   (f_ctrl_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: per channel, whether it is running and how many edges have passed since launch.
  typedef struct packed {
    logic [3:0]       busy;
    logic [3:0][31:0] age;
    logic [3:0]       done;
    logic [3:0]       err;
    logic             irq_en;
    logic             irq;
    logic [3:0]       start;
    logic             fwr;
    logic             frd;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic sel, logic rdw, logic [31:0] d, logic [3:0] dn);
    model_t n;
    logic   w;
    logic   sd;
    logic   se;
    int     elapsed;
    n = c;
    w = sel & rdw;
    n.start = '0;
    for (int i = 0; i < 4; i++) begin
      sd = 1'b0;
      se = 1'b0;
      if (c.busy[i]) begin
        elapsed = int'(c.age[i]) + 1;
        if (dn[i]) begin
          n.busy[i] = 1'b0;
          sd = 1'b1;
        end else if (TMO != 0 && elapsed == TMO + 1) begin
          n.busy[i] = 1'b0;
          se = 1'b1;
        end else begin
          n.age[i] = 32'(elapsed);
        end
      end else if (w && d[i]) begin
        n.busy[i]  = 1'b1;
        n.start[i] = 1'b1;
        n.age[i]   = '0;
      end
      n.done[i] = sd | (c.done[i] & ~(w & d[8 + i]));
      n.err[i]  = se | (c.err[i] & ~(w & d[16 + i]));
    end
    n.irq = c.irq_en & (|(c.done | c.err));
    if (w) n.irq_en = d[31];
    n.fwr = w;
    n.frd = sel & ~rdw;
    return n;
  endfunction

  function automatic logic [31:0] model_rd(model_t c);
    return {c.irq_en, 7'b0, 4'b0, c.err, 4'b0, c.done, 4'b0, c.busy};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, reg_wr_sel, reg_wr_rd, reg_wr_data, ch_done);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_rd_out", reg_rd_out, model_rd(m));
    chk("model_ch_start", 32'(ch_start), 32'(m.start));
    chk("model_ch_busy", 32'(ch_busy), 32'(m.busy));
    chk("model_irq", 32'(irq), 32'(m.irq));
    chk("model_f_ctrl_wr", 32'(f_ctrl_wr), 32'(m.fwr));
    chk("model_f_ctrl_rd", 32'(f_ctrl_rd), 32'(m.frd));
  end

  task automatic wr_reg(input logic [31:0] d);
    reg_wr_sel  = 1'b1;
    reg_wr_rd   = 1'b1;
    reg_wr_data = d;
    @(negedge clk);
    reg_wr_sel  = 1'b0;
    reg_wr_rd   = 1'b0;
    reg_wr_data = '0;
  endtask

  task automatic pulse_done(input logic [3:0] d);
    ch_done = d;
    @(negedge clk);
    ch_done = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic found;
    rst_n       = 1'b0;
    reg_wr_sel  = 1'b0;
    reg_wr_rd   = 1'b0;
    reg_wr_data = '0;
    ch_done     = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd", reg_rd_out, 32'h0);
    chk("reset_outs", {ch_start, ch_busy, irq, f_ctrl_wr, f_ctrl_rd}, 32'h0);
    rst_n = 1'b1;

    // Read strobe and read data after reset.
    reg_wr_sel = 1'b1;
    chk("read_after_reset", reg_rd_out, 32'h0);
    @(negedge clk);
    reg_wr_sel = 1'b0;
    chk("f_ctrl_rd_pulse", 32'(f_ctrl_rd), 32'h1);

    // Launch ch0 and ch2.
    wr_reg(32'h0000_0005);
    chk("start_0101", 32'(ch_start), 32'h5);
    chk("rd_busy_0101", reg_rd_out, 32'h0000_0005);
    chk("f_ctrl_wr_pulse", 32'(f_ctrl_wr), 32'h1);
    @(negedge clk);
    chk("start_one_cycle", 32'(ch_start), 32'h0);
    wr_reg(32'h0000_0001);
    chk("start_while_busy", 32'(ch_start), 32'h0);

    // Done on ch2 with IRQ_EN set.
    wr_reg(32'h8000_0000);
    pulse_done(4'b0100);
    chk("rd_done2", reg_rd_out, 32'h8000_0401);
    chk("irq_not_yet", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'h1);
    wr_reg(32'h8000_0400);
    chk("rd_done2_clr", reg_rd_out, 32'h8000_0001);
    chk("irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_drop", 32'(irq), 32'h0);

    // Done on ch0 while software clears DONE[0] on the same edge: set wins.
    ch_done = 4'b0001;
    wr_reg(32'h8000_0100);
    ch_done = '0;
    chk("set_beats_w1c", reg_rd_out, 32'h8000_0100);
    wr_reg(32'h0000_0100);
    chk("w1c_done0", reg_rd_out, 32'h0);

    // Out-of-range channel bits and reserved bits are ignored; done while idle is ignored.
    wr_reg(32'h7F00_F0F0);
    chk("reserved_ignored", reg_rd_out, 32'h0);
    chk("reserved_no_start", 32'(ch_start), 32'h0);
    pulse_done(4'b1111);
    chk("done_idle_ignored", reg_rd_out, 32'h0);

    // Timeout on ch1: ERR after TMO+1 edges.
    wr_reg(32'h0000_0002);
    k = 99;
    found = 1'b0;
    for (int j = 1; j <= 20 && !found; j++) begin
      @(negedge clk);
      if (!ch_busy[1]) begin
        found = 1'b1;
        k = j;
      end
    end
    chk("tmo_edges", 32'(k), 32'd11);
    chk("rd_err1", reg_rd_out, 32'h0002_0000);
    wr_reg(32'h0002_0000);
    chk("w1c_err1", reg_rd_out, 32'h0);

    // Done and timeout on the same edge for ch3.
    wr_reg(32'h0000_0008);
    repeat (10) @(negedge clk);
    chk("ch3_still_busy", 32'(ch_busy), 32'h8);
    pulse_done(4'b1000);
    chk("done_beats_tmo", reg_rd_out, 32'h0000_0800);
    wr_reg(32'h0000_0800);

    // Reset while ch3 is busy.
    wr_reg(32'h8000_0008);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_rd", reg_rd_out, 32'h0);
    chk("rst_mid_outs", {ch_start, ch_busy, irq, f_ctrl_wr, f_ctrl_rd}, 32'h0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_err_after_rst", reg_rd_out, 32'h0);
    chk("no_irq_after_rst", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
